mod_exp_ctrl: RTL

- Sequencer for the Montgomery-product datapath (`mon_prod`). Performs left-to-right square-and-multiply modular exponentiation.
- Per exponent bit: issues OPXX (x_bar = x_bar²), then OPXM (x_bar = x_bar·M_bar) if the bit is 1.
- After the last bit, issues OPX1 to convert x_bar out of the Montgomery domain.
- The host pre-loads memory before pulsing start: x_bar = R mod m at addr 0, M_bar at addr 2.
- This block never touches memory. `mon_prod` reads and writes addr 0 itself.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/mod_exp_ctrl_if.sv | 29 ++
 rtl/rise_det.sv | 20 ++
 rtl/mod_exp_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA exponentiation path: op codes understood by
// mon_prod, default widths, and the mod_exp_ctrl state encoding.
package rsa_pkg;

  localparam int BITLEN_DEF     = 256;
  localparam int LOG_BITLEN_DEF = 8;

  // Op codes; mon_prod decodes the same values.
  typedef enum logic [1:0] {
    OPXX = 2'd0,  // x_bar = x_bar * x_bar
    OPXM = 2'd1,  // x_bar = x_bar * M_bar
    OPX1 = 2'd2   // x_bar = x_bar * 1, leaves the Montgomery domain
  } op_e;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, NEXT, FIN_ISSUE, FIN_WAIT, DONE
  } state_e;

  typedef enum logic {SQ, MUL} phase_e;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Host/mon_prod facing signals of the exponentiation sequencer.
// slave is the controller view; master is the host + mon_prod view.
interface mod_exp_ctrl_if import rsa_pkg::*; #(
  parameter int BITLEN     = BITLEN_DEF,
  parameter int LOG_BITLEN = LOG_BITLEN_DEF
) ();

  logic                  start;
  logic [BITLEN-1:0]     exponent;
  logic [LOG_BITLEN:0]   exp_len;
  logic                  mp_stop;
  logic                  mp_start;
  op_e                   mp_op_code;
  logic [LOG_BITLEN:0]   mp_count;
  logic                  busy;
  logic                  done;
  logic [LOG_BITLEN+2:0] ops_issued;

  modport slave (
    input  start, exponent, exp_len, mp_stop,
    output mp_start, mp_op_code, mp_count, busy, done, ops_issued
  );

  modport master (
    output start, exponent, exp_len, mp_stop,
    input  mp_start, mp_op_code, mp_count, busy, done, ops_issued
  );

endinterface

// File: rtl/rise_det.sv
// Single-bit rising-edge detector; used to turn mon_prod's stop level into a
// one-cycle completion event.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Previous-cycle copy of d.
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for mon_prod.
// Each exponent bit issues OPXX, then OPXM if the bit is 1; a final OPX1
// converts the result out of the Montgomery domain. Operands live in
// mon_prod's memory; this block only sequences op codes.
module mod_exp_ctrl import rsa_pkg::*; #(
  parameter int BITLEN     = BITLEN_DEF,
  parameter int LOG_BITLEN = LOG_BITLEN_DEF,
  parameter int MP_COUNT   = BITLEN
) (
  input  logic            clk,
  input  logic            rst,
  mod_exp_ctrl_if.slave   bus
);

  localparam int LW = LOG_BITLEN + 1;
  localparam int OW = LOG_BITLEN + 3;

  state_e            state;
  phase_e            phase;
  logic [BITLEN-1:0] esr;   // exponent, MSB-aligned, consumed from the top
  logic [LW-1:0]     idx;   // exponent bits still to process
  logic [LW-1:0]     len_c;
  logic [LW-1:0]     sh_c;
  logic              mp_done_evt;

  assign bus.mp_count = LW'(MP_COUNT);

  // Clamp the requested length and derive the alignment shift.
  always_comb begin
    len_c = (bus.exp_len > LW'(BITLEN)) ? LW'(BITLEN) : bus.exp_len;
    sh_c  = LW'(BITLEN) - len_c;
  end

  // A stop level left high from a previous op must not complete the current one.
  rise_det u_stop_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.mp_stop),
    .rise (mp_done_evt)
  );

  // Sequencer; mp_start/mp_op_code are set on entry to an issue state so they
  // are valid for the whole issue cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      phase          <= SQ;
      esr            <= '0;
      idx            <= '0;
      bus.mp_start   <= 1'b0;
      bus.mp_op_code <= OPXX;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.ops_issued <= '0;
    end else begin
      bus.mp_start <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            esr            <= bus.exponent << sh_c;
            idx            <= len_c;
            bus.ops_issued <= '0;
            bus.busy       <= 1'b1;
            phase          <= SQ;
            bus.mp_start   <= 1'b1;
            if (len_c == '0) begin
              bus.mp_op_code <= OPX1;
              state          <= FIN_ISSUE;
            end else begin
              bus.mp_op_code <= OPXX;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.ops_issued <= bus.ops_issued + OW'(1);
          state          <= WAIT;
        end
        WAIT: begin
          if (mp_done_evt) state <= NEXT;
        end
        NEXT: begin
          bus.mp_start <= 1'b1;
          if (phase == SQ && esr[BITLEN-1]) begin
            phase          <= MUL;
            bus.mp_op_code <= OPXM;
            state          <= ISSUE;
          end else begin
            esr   <= esr << 1;
            idx   <= idx - LW'(1);
            phase <= SQ;
            if (idx != LW'(1)) begin
              bus.mp_op_code <= OPXX;
              state          <= ISSUE;
            end else begin
              bus.mp_op_code <= OPX1;
              state          <= FIN_ISSUE;
            end
          end
        end
        FIN_ISSUE: begin
          bus.ops_issued <= bus.ops_issued + OW'(1);
          state          <= FIN_WAIT;
        end
        FIN_WAIT: begin
          if (mp_done_evt) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
